chnl_slave: RTL and testbench
=============================

CHNL_SLAVE -- requirements
Module: chnl_slave

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32; FIFO depth in words, a power of two, minimum 4.
REQ-002 The block SHALL have parameter CW, default $clog2(DEPTH)+1; occupancy and margin width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port chnl_en  input  1  channel enable from the register block.
REQ-006 The block SHALL have port ch_data  input  32  channel data word.
REQ-007 The block SHALL have port ch_data_p  input  1  channel parity bit.
REQ-008 The block SHALL have port ch_valid  input  1  channel word valid.
REQ-009 The block SHALL have port ch_wait  output  1  backpressure to the channel master.
REQ-010 The block SHALL have port ch_parity_err  output  1  parity error pulse.
REQ-011 The block SHALL have port slv_val  output  1  FIFO head valid toward the arbiter.
REQ-012 The block SHALL have port slv_data  output  32  FIFO head word, show-ahead.
REQ-013 The block SHALL have port slv_margin  output  CW  free FIFO slots, DEPTH minus occupancy.
REQ-014 The block SHALL have port a2s_ack  input  1  arbiter pop request.

Function
REQ-015 ch_wait SHALL be combinational: high when chnl_en=0 or occupancy==DEPTH, else low.
REQ-016 A beat SHALL be accepted on a rising edge when ch_valid=1 and ch_wait=0.
REQ-017 Parity SHALL be even: an accepted beat is good when ch_data_p equals the XOR reduction of ch_data.
REQ-018 A good accepted beat SHALL be written at the write pointer, and occupancy SHALL increment at the same edge.
REQ-019 A bad-parity accepted beat SHALL NOT be written and SHALL set ch_parity_err for exactly the next cycle; back-to-back bad beats SHALL hold ch_parity_err high for consecutive cycles.
REQ-020 slv_val SHALL be high exactly when occupancy is nonzero, independent of chnl_en.
REQ-021 slv_data SHALL present the oldest stored word whenever slv_val=1; its value SHALL be don't-care when slv_val=0.
REQ-022 A pop SHALL occur when a2s_ack=1 and slv_val=1; a2s_ack while empty SHALL be ignored with no pointer or occupancy change.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged and advance both pointers.
REQ-024 Push when full SHALL be impossible (ch_wait=1); pop when full SHALL be permitted, and ch_wait SHALL drop in the following cycle.
REQ-025 Pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0; occupancy SHALL be a separate CW-bit counter, range 0..DEPTH.
REQ-026 Latency SHALL be one cycle: a word written at edge N is visible on slv_data with slv_val=1 after edge N, and poppable at edge N+1.
REQ-027 slv_margin SHALL equal DEPTH minus occupancy, registered-consistent with occupancy in the same cycle.
REQ-028 Deasserting chnl_en SHALL block new writes only; stored words SHALL be retained and remain drainable.
REQ-029 Words SHALL leave in strict write order, with no duplication or loss except parity-dropped beats.

Reset
REQ-030 While rstn=0, pointers and occupancy SHALL be 0, slv_val=0, ch_parity_err=0, and slv_margin=DEPTH.
REQ-031 While rstn=0 with chnl_en=0, ch_wait SHALL be 1; with chnl_en=1, ch_wait SHALL be 0, per REQ-015.
REQ-032 Reset asserted mid-transfer SHALL discard all stored words immediately and asynchronously; a beat presented during reset SHALL NOT be stored.
REQ-033 FIFO storage array SHALL NOT require reset.

Verification
REQ-034 Scenario: chnl_en=1; write 0x0000_0001 (p=1), 0x0000_0003 (p=0) -> slv_val=1, slv_data=0x0000_0001, margin=30; ack twice -> 0x0000_0003 then slv_val=0, margin=32.
REQ-035 Scenario: write 32 good words with no ack -> ch_wait=1 and margin=0 after the 32nd edge; 33rd ch_valid not accepted; one ack -> ch_wait=0 next cycle.
REQ-036 Scenario: send 0xFFFF_FFFF with p=1 -> ch_parity_err high for one cycle, occupancy unchanged, slv_val stays 0.
REQ-037 Scenario: at occupancy 5, ch_valid and a2s_ack every cycle for 40 cycles -> occupancy stays 5, order preserved across pointer wrap.
REQ-038 Scenario: load 3 words, drop chnl_en -> ch_wait=1, ch_valid ignored, 3 words still drained in order.
REQ-039 Scenario: load 10 words, pulse rstn low mid-cycle -> slv_val=0 and margin=32 immediately; a2s_ack after reset ignored.

Source files
------------

// File: rtl/chnl_slave.sv
// Generic show-ahead synchronous FIFO with a separate occupancy counter.
// Latency: a word written at edge N is visible on rd_dat after edge N.
// Backpressure: writes are dropped when full; reads are ignored when empty.
module fifo #(
    parameter int DEPTH = 32,
    parameter int W     = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_rdy,
    output logic          rd_vld,
    output logic [W-1:0]  rd_dat,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign push   = wr_vld && (count != CW'(DEPTH));
    assign rd_vld = (count != '0);
    assign pop    = rd_rdy && rd_vld;
    assign rd_dat = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Channel slave: parity-checks channel beats and queues good ones for the arbiter.
// Latency: one cycle from accepted beat to slv_val/slv_data.
// Backpressure: ch_wait is raised combinationally when disabled or the FIFO is full.
module chnl_slave #(
    parameter int DEPTH = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          chnl_en,
    input  logic [31:0]   ch_data,
    input  logic          ch_data_p,
    input  logic          ch_valid,
    output logic          ch_wait,
    output logic          ch_parity_err,
    output logic          slv_val,
    output logic [31:0]   slv_data,
    output logic [CW-1:0] slv_margin,
    input  logic          a2s_ack
);
    logic [CW-1:0] occ;
    logic          accept;
    logic          par_ok;
    logic          push;

    assign ch_wait    = !chnl_en || (occ == CW'(DEPTH));
    assign accept     = ch_valid && !ch_wait;
    assign par_ok     = (ch_data_p == ^ch_data);
    assign push       = accept && par_ok;
    assign slv_margin = CW'(DEPTH) - occ;

    // Bad beats are consumed from the channel but never stored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ch_parity_err <= 1'b0;
        end else begin
            ch_parity_err <= accept && !par_ok;
        end
    end

    fifo #(
        .DEPTH (DEPTH),
        .W     (32),
        .CW    (CW)
    ) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .wr_vld (push),
        .wr_dat (ch_data),
        .rd_rdy (a2s_ack),
        .rd_vld (slv_val),
        .rd_dat (slv_data),
        .count  (occ)
    );
endmodule

// File: tb/tb_chnl_slave.sv
// Directed self-checking bench for chnl_slave with a queue reference model.
module tb_chnl_slave;
    logic        clk = 1'b0;
    logic        rstn;
    logic        chnl_en;
    logic [31:0] ch_data;
    logic        ch_data_p;
    logic        ch_valid;
    logic        ch_wait;
    logic        ch_parity_err;
    logic        slv_val;
    logic [31:0] slv_data;
    logic [5:0]  slv_margin;
    logic        a2s_ack;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] q[$];
    logic [31:0] exp_w;

    chnl_slave dut (
        .clk           (clk),
        .rstn          (rstn),
        .chnl_en       (chnl_en),
        .ch_data       (ch_data),
        .ch_data_p     (ch_data_p),
        .ch_valid      (ch_valid),
        .ch_wait       (ch_wait),
        .ch_parity_err (ch_parity_err),
        .slv_val       (slv_val),
        .slv_data      (slv_data),
        .slv_margin    (slv_margin),
        .a2s_ack       (a2s_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for one edge; good beats are recorded in the model.
    task automatic write_word(input logic [31:0] d, input logic good);
        ch_data   = d;
        ch_data_p = (^d) ^ ~good;
        ch_valid  = 1'b1;
        tick();
        ch_valid  = 1'b0;
        if (good) q.push_back(d);
    endtask

    task automatic drain(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            exp_w = q.pop_front();
            chk({tag, "_val"}, 32'(slv_val), 32'd1);
            chk({tag, "_data"}, slv_data, exp_w);
            a2s_ack = 1'b1;
            tick();
            a2s_ack = 1'b0;
        end
    endtask

    initial begin
        rstn      = 1'b0;
        chnl_en   = 1'b0;
        ch_data   = '0;
        ch_data_p = 1'b0;
        ch_valid  = 1'b0;
        a2s_ack   = 1'b0;

        // Reset state
        #12;
        chk("rst_wait_dis", 32'(ch_wait), 32'd1);
        chk("rst_val", 32'(slv_val), 32'd0);
        chk("rst_margin", 32'(slv_margin), 32'd32);
        chk("rst_perr", 32'(ch_parity_err), 32'd0);
        chnl_en   = 1'b1;
        ch_data   = 32'h0000_0001;
        ch_data_p = 1'b1;
        ch_valid  = 1'b1;
        #1;
        chk("rst_wait_en", 32'(ch_wait), 32'd0);
        tick();
        chk("rst_beat_val", 32'(slv_val), 32'd0);
        chk("rst_beat_margin", 32'(slv_margin), 32'd32);
        ch_valid = 1'b0;
        rstn     = 1'b1;
        tick();
        chk("post_rst_val", 32'(slv_val), 32'd0);

        // Basic write/read with latency check
        write_word(32'h0000_0001, 1'b1);
        chk("lat_val", 32'(slv_val), 32'd1);
        chk("lat_data", slv_data, 32'h0000_0001);
        chk("lat_margin", 32'(slv_margin), 32'd31);
        write_word(32'h0000_0003, 1'b1);
        chk("two_margin", 32'(slv_margin), 32'd30);
        chk("two_head", slv_data, 32'h0000_0001);
        drain(2, "basic");
        chk("basic_empty_val", 32'(slv_val), 32'd0);
        chk("basic_empty_margin", 32'(slv_margin), 32'd32);
        a2s_ack = 1'b1;
        tick();
        a2s_ack = 1'b0;
        chk("ack_empty_margin", 32'(slv_margin), 32'd32);
        chk("ack_empty_val", 32'(slv_val), 32'd0);

        // Parity errors, single and back-to-back
        write_word(32'hFFFF_FFFF, 1'b0);
        chk("perr_pulse", 32'(ch_parity_err), 32'd1);
        chk("perr_val", 32'(slv_val), 32'd0);
        chk("perr_margin", 32'(slv_margin), 32'd32);
        tick();
        chk("perr_clear", 32'(ch_parity_err), 32'd0);
        write_word(32'h1234_5678, 1'b0);
        chk("perr_b2b_1", 32'(ch_parity_err), 32'd1);
        write_word(32'h0000_0007, 1'b0);
        chk("perr_b2b_2", 32'(ch_parity_err), 32'd1);
        chk("perr_b2b_margin", 32'(slv_margin), 32'd32);
        tick();
        chk("perr_b2b_clear", 32'(ch_parity_err), 32'd0);

        // Fill to full
        for (int i = 0; i < 32; i++) begin
            write_word(32'hC0DE_0000 + 32'(i * 7), 1'b1);
        end
        chk("full_wait", 32'(ch_wait), 32'd1);
        chk("full_margin", 32'(slv_margin), 32'd0);
        ch_data   = 32'hDEAD_BEEF;
        ch_data_p = ^ch_data;
        ch_valid  = 1'b1;
        tick();
        chk("full_33rd_margin", 32'(slv_margin), 32'd0);
        a2s_ack = 1'b1;
        tick();
        a2s_ack  = 1'b0;
        ch_valid = 1'b0;
        void'(q.pop_front());
        chk("full_pop_wait", 32'(ch_wait), 32'd0);
        chk("full_pop_margin", 32'(slv_margin), 32'd1);
        drain(31, "full");
        chk("full_drained", 32'(slv_margin), 32'd32);

        // Streaming at occupancy 5 across pointer wrap
        for (int i = 0; i < 5; i++) begin
            write_word(32'h5000_0000 + 32'(i), 1'b1);
        end
        for (int i = 0; i < 40; i++) begin
            chk("stream_head", slv_data, q[0]);
            ch_data   = 32'hA000_0000 + 32'(i * 3);
            ch_data_p = ^ch_data;
            ch_valid  = 1'b1;
            a2s_ack   = 1'b1;
            tick();
            void'(q.pop_front());
            q.push_back(ch_data);
            chk("stream_margin", 32'(slv_margin), 32'd27);
        end
        ch_valid = 1'b0;
        a2s_ack  = 1'b0;
        drain(5, "stream");
        chk("stream_empty", 32'(slv_val), 32'd0);

        // Channel disable retains and drains stored words
        for (int i = 0; i < 3; i++) begin
            write_word(32'h7700_0000 + 32'(i), 1'b1);
        end
        chnl_en = 1'b0;
        #1;
        chk("dis_wait", 32'(ch_wait), 32'd1);
        ch_data   = 32'hBAD0_0001;
        ch_data_p = ^ch_data;
        ch_valid  = 1'b1;
        tick();
        tick();
        ch_valid = 1'b0;
        chk("dis_margin", 32'(slv_margin), 32'd29);
        drain(3, "dis");
        chk("dis_empty", 32'(slv_val), 32'd0);
        chnl_en = 1'b1;

        // Asynchronous reset mid-transfer
        for (int i = 0; i < 10; i++) begin
            write_word(32'h9900_0000 + 32'(i), 1'b1);
        end
        chk("prerst_margin", 32'(slv_margin), 32'd22);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_val", 32'(slv_val), 32'd0);
        chk("arst_margin", 32'(slv_margin), 32'd32);
        q.delete();
        tick();
        rstn    = 1'b1;
        a2s_ack = 1'b1;
        tick();
        a2s_ack = 1'b0;
        chk("arst_ack_margin", 32'(slv_margin), 32'd32);
        chk("arst_ack_val", 32'(slv_val), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
